uart_rx_fsm: RTL and testbench

Control state machine for the UART receive path. It detects the start-bit falling edge on the oversampled RX line and runs the edge and bit counters. It issues one-cycle enables to the sampling, deserializer and start/parity/stop checker stages, evaluates their error flags at bit boundaries, and emits a one-cycle frame-complete or frame-error pulse. It sits directly upstream of the start, parity and stop checkers and consumes their registered error outputs.

---
 rtl/uart_rx_pkg.sv | 24 ++
 rtl/uart_rx_fsm_edge_bit_counter.sv | 65 ++++++
 rtl/uart_rx_fsm.sv | 180 ++++++++++++++++++
 tb/tb_uart_rx_fsm.sv | 370 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_pkg.sv
`default_nettype none
//=============================================================================
// Module   : uart_rx_pkg
// Brief    : Shared types and default constants for the UART receive control
//            path (FSM state encoding, default frame geometry).
// Revision : 1.0 - initial release
//=============================================================================
package uart_rx_pkg;

   // Default oversampling ratio (clk2 cycles per bit); must be even and >= 4.
   localparam int unsigned DEF_PRESCALE  = 8;
   // Default number of data bits per frame; must be >= 2.
   localparam int unsigned DEF_DATA_BITS = 8;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } rx_state_e;

endpackage : uart_rx_pkg
`default_nettype wire

// File: rtl/uart_rx_fsm_edge_bit_counter.sv
`default_nettype none
//=============================================================================
// Module   : edge_bit_counter
// Brief    : Oversample edge counter (0..PRESCALE-1, wrapping) and data-bit
//            counter for the UART receive FSM.
// Ports    : clk2     - oversampling clock
//            rst      - asynchronous active-low reset
//            cnt_en   - advance edge_cnt (and bit_cnt when bit_inc)
//            clr      - synchronous clear of both counters (has priority)
//            bit_inc  - increment bit_cnt together with this edge step
//            edge_cnt - current oversample position within the bit
//            bit_cnt  - index of the data bit currently being received
// Revision : 1.0 - initial release
//=============================================================================
module edge_bit_counter
   import uart_rx_pkg::*;
#(
   parameter int unsigned PRESCALE  = DEF_PRESCALE,
   parameter int unsigned DATA_BITS = DEF_DATA_BITS
) (
   input  logic                         clk2,
   input  logic                         rst,
   input  logic                         cnt_en,
   input  logic                         clr,
   input  logic                         bit_inc,
   output logic [$clog2(PRESCALE)-1:0]  edge_cnt,
   output logic [$clog2(DATA_BITS)-1:0] bit_cnt
);

   localparam int unsigned   EW        = $clog2(PRESCALE);
   localparam int unsigned   BW        = $clog2(DATA_BITS);
   localparam logic [EW-1:0] LAST_EDGE = EW'(PRESCALE - 1);

   logic [EW-1:0] edge_cnt_q, edge_cnt_d;
   logic [BW-1:0] bit_cnt_q,  bit_cnt_d;

   always_comb begin
      edge_cnt_d = edge_cnt_q;
      bit_cnt_d  = bit_cnt_q;
      if (clr) begin
         edge_cnt_d = '0;
         bit_cnt_d  = '0;
      end else if (cnt_en) begin
         edge_cnt_d = (edge_cnt_q == LAST_EDGE) ? '0 : edge_cnt_q + 1'b1;
         if (bit_inc) begin
            bit_cnt_d = bit_cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk2 or negedge rst) begin
      if (!rst) begin
         edge_cnt_q <= '0;
         bit_cnt_q  <= '0;
      end else begin
         edge_cnt_q <= edge_cnt_d;
         bit_cnt_q  <= bit_cnt_d;
      end
   end

   assign edge_cnt = edge_cnt_q;
   assign bit_cnt  = bit_cnt_q;

endmodule : edge_bit_counter
`default_nettype wire

// File: rtl/uart_rx_fsm.sv
`default_nettype none
//=============================================================================
// Module   : uart_rx_fsm
// Brief    : UART receive control FSM. Detects the start-bit falling edge,
//            sequences START/DATA/PARITY/STOP, issues one-cycle stage enables
//            and emits a one-cycle frame result pulse.
// Ports    : clk2, rst (async active-low)
//            data_in                     - synchronized RX line, idle high
//            par_en                      - parity present (latched per frame)
//            start_err/par_err/stop_err  - registered checker flags
//            start_chk_en, data_samp_en, deser_en, par_chk_en, stop_chk_en
//                                        - one-cycle stage enables
//            bit_idx                     - data bit index being sampled
//            data_valid/frame_err/parity_err - one-cycle result pulses
// Revision : 1.0 - initial release
//=============================================================================
module uart_rx_fsm
   import uart_rx_pkg::*;
#(
   parameter int unsigned PRESCALE  = DEF_PRESCALE,
   parameter int unsigned DATA_BITS = DEF_DATA_BITS
) (
   input  logic                         clk2,
   input  logic                         rst,
   input  logic                         data_in,
   input  logic                         par_en,
   input  logic                         start_err,
   input  logic                         par_err,
   input  logic                         stop_err,
   output logic                         start_chk_en,
   output logic                         data_samp_en,
   output logic                         deser_en,
   output logic                         par_chk_en,
   output logic                         stop_chk_en,
   output logic [$clog2(DATA_BITS)-1:0] bit_idx,
   output logic                         data_valid,
   output logic                         frame_err,
   output logic                         parity_err
);

   localparam int unsigned   EW        = $clog2(PRESCALE);
   localparam int unsigned   BW        = $clog2(DATA_BITS);
   localparam logic [EW-1:0] LAST_EDGE = EW'(PRESCALE - 1);
   // Enables are registered, so they are decoded one edge before
   // SAMPLE_EDGE (PRESCALE/2-1) and appear while edge_cnt == SAMPLE_EDGE.
   localparam logic [EW-1:0] PRE_SAMPLE = EW'(PRESCALE / 2 - 2);
   localparam logic [BW-1:0] LAST_BIT   = BW'(DATA_BITS - 1);

   rx_state_e     state_q, state_d;
   logic          par_en_q, par_en_d;
   logic          err_p_q, err_p_d;
   logic          start_chk_en_q, start_chk_en_d;
   logic          data_samp_en_q, data_samp_en_d;
   logic          par_chk_en_q, par_chk_en_d;
   logic          stop_chk_en_q, stop_chk_en_d;
   logic          data_valid_q, data_valid_d;
   logic          frame_err_q, frame_err_d;
   logic          parity_err_q, parity_err_d;

   logic [EW-1:0] edge_cnt;
   logic [BW-1:0] bit_cnt;
   logic          cnt_clr, cnt_en, bit_inc;
   logic          at_pre, at_last;

   assign at_pre  = (edge_cnt == PRE_SAMPLE);
   assign at_last = (edge_cnt == LAST_EDGE);

   always_comb begin
      state_d        = state_q;
      par_en_d       = par_en_q;
      err_p_d        = err_p_q;
      start_chk_en_d = 1'b0;
      data_samp_en_d = 1'b0;
      par_chk_en_d   = 1'b0;
      stop_chk_en_d  = 1'b0;
      data_valid_d   = 1'b0;
      frame_err_d    = 1'b0;
      parity_err_d   = 1'b0;
      bit_inc        = 1'b0;

      case (state_q)
         IDLE: begin
            if (!data_in) begin
               state_d  = START;
               par_en_d = par_en;
               err_p_d  = 1'b0;
            end
         end
         START: begin
            start_chk_en_d = at_pre;
            // A failed start check means the low pulse was a glitch:
            // drop back silently.
            if (at_last) begin
               state_d = start_err ? IDLE : DATA;
            end
         end
         DATA: begin
            data_samp_en_d = at_pre;
            if (at_last) begin
               bit_inc = 1'b1;
               if (bit_cnt == LAST_BIT) begin
                  state_d = par_en_q ? PARITY : STOP;
               end
            end
         end
         PARITY: begin
            par_chk_en_d = at_pre;
            if (at_last) begin
               err_p_d = par_err;
               state_d = STOP;
            end
         end
         STOP: begin
            stop_chk_en_d = at_pre;
            if (at_last) begin
               state_d      = IDLE;
               data_valid_d = !stop_err && !err_p_q;
               frame_err_d  = stop_err;
               parity_err_d = err_p_q;
            end
         end
         default: state_d = IDLE;
      endcase

      // Counters sit at zero throughout IDLE, so START always begins at edge 0.
      cnt_clr = (state_q == IDLE) || (state_d == IDLE);
      cnt_en  = (state_q != IDLE);
   end

   edge_bit_counter #(
      .PRESCALE  (PRESCALE),
      .DATA_BITS (DATA_BITS)
   ) u_edge_bit_counter (
      .clk2     (clk2),
      .rst      (rst),
      .cnt_en   (cnt_en),
      .clr      (cnt_clr),
      .bit_inc  (bit_inc),
      .edge_cnt (edge_cnt),
      .bit_cnt  (bit_cnt)
   );

   always_ff @(posedge clk2 or negedge rst) begin
      if (!rst) begin
         state_q        <= IDLE;
         par_en_q       <= 1'b0;
         err_p_q        <= 1'b0;
         start_chk_en_q <= 1'b0;
         data_samp_en_q <= 1'b0;
         par_chk_en_q   <= 1'b0;
         stop_chk_en_q  <= 1'b0;
         data_valid_q   <= 1'b0;
         frame_err_q    <= 1'b0;
         parity_err_q   <= 1'b0;
      end else begin
         state_q        <= state_d;
         par_en_q       <= par_en_d;
         err_p_q        <= err_p_d;
         start_chk_en_q <= start_chk_en_d;
         data_samp_en_q <= data_samp_en_d;
         par_chk_en_q   <= par_chk_en_d;
         stop_chk_en_q  <= stop_chk_en_d;
         data_valid_q   <= data_valid_d;
         frame_err_q    <= frame_err_d;
         parity_err_q   <= parity_err_d;
      end
   end

   assign start_chk_en = start_chk_en_q;
   assign data_samp_en = data_samp_en_q;
   assign deser_en     = data_samp_en_q;
   assign par_chk_en   = par_chk_en_q;
   assign stop_chk_en  = stop_chk_en_q;
   assign bit_idx      = bit_cnt;
   assign data_valid   = data_valid_q;
   assign frame_err    = frame_err_q;
   assign parity_err   = parity_err_q;

endmodule : uart_rx_fsm
`default_nettype wire

// File: tb/tb_uart_rx_fsm.sv
`default_nettype none
`timescale 1ns/1ps
//=============================================================================
// Module   : tb_uart_rx_fsm
// Brief    : Directed self-checking bench for uart_rx_fsm (PRESCALE=8,
//            DATA_BITS=8). "rel" is the cycle index counted from the cycle in
//            which data_in first goes low (rel 0); outputs are sampled 1 ns
//            after each rising clk2 edge and inputs are driven right after.
// Revision : 1.0 - initial release
//=============================================================================
module tb_uart_rx_fsm;

   localparam int PRESCALE  = 8;
   localparam int DATA_BITS = 8;

   logic       clk2;
   logic       rst;
   logic       data_in, par_en, start_err, par_err, stop_err;
   logic       start_chk_en, data_samp_en, deser_en, par_chk_en, stop_chk_en;
   logic [2:0] bit_idx;
   logic       data_valid, frame_err, parity_err;
   logic [10:0] outs;

   int n_cmp = 0;
   int n_bad = 0;

   assign outs = {start_chk_en, data_samp_en, deser_en, par_chk_en, stop_chk_en,
                  bit_idx, data_valid, frame_err, parity_err};

   uart_rx_fsm #(.PRESCALE(PRESCALE), .DATA_BITS(DATA_BITS)) dut (
      .clk2         (clk2),
      .rst          (rst),
      .data_in      (data_in),
      .par_en       (par_en),
      .start_err    (start_err),
      .par_err      (par_err),
      .stop_err     (stop_err),
      .start_chk_en (start_chk_en),
      .data_samp_en (data_samp_en),
      .deser_en     (deser_en),
      .par_chk_en   (par_chk_en),
      .stop_chk_en  (stop_chk_en),
      .bit_idx      (bit_idx),
      .data_valid   (data_valid),
      .frame_err    (frame_err),
      .parity_err   (parity_err)
   );

   initial clk2 = 1'b0;
   always #5 clk2 = ~clk2;

   task automatic tick();
      @(posedge clk2);
      #1;
   endtask

   // Line level at offset rel within a frame: start, data LSB first,
   // optional parity, stop, then idle high.
   function automatic logic frame_line(input int rel, input logic [7:0] d,
                                       input logic with_par, input logic par_bit,
                                       input logic stop_val);
      int b;
      if (rel < 0) return 1'b1;
      b = rel / PRESCALE;
      if (b == 0) return 1'b0;
      if (b <= DATA_BITS) return d[b-1];
      if (with_par && b == DATA_BITS + 1) return par_bit;
      if (b == DATA_BITS + 1 + int'(with_par)) return stop_val;
      return 1'b1;
   endfunction

   function automatic int q_at(input int q[$], input int i);
      return (i < q.size()) ? q[i] : -1;
   endfunction

   task automatic idle_line(input int n);
      data_in = 1'b1;
      repeat (n) tick();
   endtask

   task automatic test_reset();
      rst = 1'b0; data_in = 1'b1; par_en = 1'b0;
      start_err = 1'b0; par_err = 1'b0; stop_err = 1'b0;
      repeat (3) tick();
      n_cmp++;
      if (outs !== 11'd0) begin
         n_bad++;
         $display("FAIL reset_outputs: got %b, required all zero", outs);
      end
      rst = 1'b1;
      repeat (4) tick();
      n_cmp++;
      if (outs !== 11'd0) begin
         n_bad++;
         $display("FAIL idle_outputs: got %b, required all zero", outs);
      end
   endtask

   // 0xA5, no parity, clean checkers.
   task automatic test_clean_frame();
      int st[$]; int sp[$]; int ix[$]; int vl[$]; int stp[$];
      int other = 0, deser_bad = 0;
      idle_line(4);
      par_en = 1'b0;
      data_in = 1'b0;                                    // rel 0
      for (int rel = 1; rel <= 100; rel++) begin
         tick();
         if (start_chk_en) st.push_back(rel);
         if (data_samp_en) begin sp.push_back(rel); ix.push_back(int'(bit_idx)); end
         if (deser_en !== data_samp_en) deser_bad++;
         if (stop_chk_en) stp.push_back(rel);
         if (data_valid) vl.push_back(rel);
         if (frame_err || parity_err || par_chk_en) other++;
         data_in = frame_line(rel, 8'hA5, 1'b0, 1'b0, 1'b1);
      end
      n_cmp++;
      if (st.size() != 1 || q_at(st, 0) != 4) begin
         n_bad++;
         $display("FAIL clean_start_chk: count %0d first %0d, required 1 at 4", st.size(), q_at(st, 0));
      end
      n_cmp++;
      if (sp.size() != 8) begin
         n_bad++;
         $display("FAIL clean_samp_count: got %0d, required 8", sp.size());
      end
      for (int k = 0; k < 8; k++) begin
         n_cmp++;
         if (q_at(sp, k) != 12 + 8 * k || q_at(ix, k) != k) begin
            n_bad++;
            $display("FAIL clean_samp_%0d: at %0d idx %0d, required at %0d idx %0d",
                     k, q_at(sp, k), q_at(ix, k), 12 + 8 * k, k);
         end
      end
      n_cmp++;
      if (deser_bad != 0) begin
         n_bad++;
         $display("FAIL clean_deser_en: %0d cycles differ from data_samp_en, required 0", deser_bad);
      end
      n_cmp++;
      if (stp.size() != 1 || q_at(stp, 0) != 76) begin
         n_bad++;
         $display("FAIL clean_stop_chk: count %0d first %0d, required 1 at 76", stp.size(), q_at(stp, 0));
      end
      n_cmp++;
      if (vl.size() != 1 || q_at(vl, 0) != 81) begin
         n_bad++;
         $display("FAIL clean_data_valid: count %0d first %0d, required 1 at 81", vl.size(), q_at(vl, 0));
      end
      n_cmp++;
      if (other != 0) begin
         n_bad++;
         $display("FAIL clean_no_err: %0d stray pulses, required 0", other);
      end
   endtask

   // Two-cycle low glitch rejected by start_err; a real frame (0xFF) then
   // starts at rel 9, right after the FSM is back in IDLE.
   task automatic test_glitch();
      int st[$]; int sp[$]; int vl[$];
      int other = 0;
      idle_line(4);
      data_in = 1'b0;                                    // rel 0
      for (int rel = 1; rel <= 100; rel++) begin
         tick();
         if (start_chk_en) st.push_back(rel);
         if (data_samp_en) sp.push_back(rel);
         if (data_valid) vl.push_back(rel);
         if (frame_err || parity_err) other++;
         start_err = (rel >= 5 && rel <= 8);
         if (rel < 2)      data_in = 1'b0;
         else if (rel < 9) data_in = 1'b1;
         else              data_in = frame_line(rel - 9, 8'hFF, 1'b0, 1'b0, 1'b1);
      end
      n_cmp++;
      if (st.size() != 2 || q_at(st, 0) != 4 || q_at(st, 1) != 13) begin
         n_bad++;
         $display("FAIL glitch_start_chk: count %0d at %0d,%0d, required 2 at 4,13",
                  st.size(), q_at(st, 0), q_at(st, 1));
      end
      n_cmp++;
      if (sp.size() != 8 || q_at(sp, 0) != 21) begin
         n_bad++;
         $display("FAIL glitch_no_samp: count %0d first %0d, required 8 first at 21", sp.size(), q_at(sp, 0));
      end
      n_cmp++;
      if (vl.size() != 1 || q_at(vl, 0) != 90 || other != 0) begin
         n_bad++;
         $display("FAIL glitch_result: valid count %0d first %0d errs %0d, required 1 at 90 errs 0",
                  vl.size(), q_at(vl, 0), other);
      end
   endtask

   // Parity frame, par_en dropped mid-frame, par_err raised after par_chk_en.
   task automatic test_parity();
      int pc[$]; int stp[$]; int pe[$]; int sp[$];
      int nv = 0, nf = 0;
      idle_line(4);
      par_en = 1'b1;
      data_in = 1'b0;                                    // rel 0
      for (int rel = 1; rel <= 100; rel++) begin
         tick();
         if (par_chk_en) pc.push_back(rel);
         if (stop_chk_en) stp.push_back(rel);
         if (parity_err) pe.push_back(rel);
         if (data_samp_en) sp.push_back(rel);
         if (data_valid) nv++;
         if (frame_err) nf++;
         par_en  = 1'b0;
         par_err = (rel >= 77 && rel <= 90);
         data_in = frame_line(rel, 8'h3C, 1'b1, 1'b1, 1'b1);
      end
      n_cmp++;
      if (pc.size() != 1 || q_at(pc, 0) != 76) begin
         n_bad++;
         $display("FAIL parity_chk_en: count %0d first %0d, required 1 at 76", pc.size(), q_at(pc, 0));
      end
      n_cmp++;
      if (stp.size() != 1 || q_at(stp, 0) != 84 || sp.size() != 8) begin
         n_bad++;
         $display("FAIL parity_stop_chk: count %0d first %0d samp %0d, required 1 at 84 samp 8",
                  stp.size(), q_at(stp, 0), sp.size());
      end
      n_cmp++;
      if (pe.size() != 1 || q_at(pe, 0) != 89) begin
         n_bad++;
         $display("FAIL parity_err_pulse: count %0d first %0d, required 1 at 89", pe.size(), q_at(pe, 0));
      end
      n_cmp++;
      if (nv != 0 || nf != 0) begin
         n_bad++;
         $display("FAIL parity_no_valid: data_valid %0d frame_err %0d, required 0 and 0", nv, nf);
      end
   endtask

   // Stop bit held low (break): frame_err, immediate restart, and the
   // all-zero break frame errors again.
   task automatic test_stop_err();
      int st[$]; int fe[$];
      int nv = 0, np = 0;
      idle_line(4);
      data_in = 1'b0;                                    // rel 0
      for (int rel = 1; rel <= 175; rel++) begin
         tick();
         if (start_chk_en) st.push_back(rel);
         if (frame_err) fe.push_back(rel);
         if (data_valid) nv++;
         if (parity_err) np++;
         stop_err = (rel >= 77);
         if (rel < 72)       data_in = frame_line(rel, 8'h0F, 1'b0, 1'b0, 1'b1);
         else if (rel < 162) data_in = 1'b0;
         else                data_in = 1'b1;
      end
      stop_err = 1'b0;
      n_cmp++;
      if (fe.size() != 2 || q_at(fe, 0) != 81 || q_at(fe, 1) != 162) begin
         n_bad++;
         $display("FAIL stop_frame_err: count %0d at %0d,%0d, required 2 at 81,162",
                  fe.size(), q_at(fe, 0), q_at(fe, 1));
      end
      n_cmp++;
      if (st.size() != 2 || q_at(st, 0) != 4 || q_at(st, 1) != 85) begin
         n_bad++;
         $display("FAIL stop_restart: start_chk count %0d at %0d,%0d, required 2 at 4,85",
                  st.size(), q_at(st, 0), q_at(st, 1));
      end
      n_cmp++;
      if (nv != 0 || np != 0) begin
         n_bad++;
         $display("FAIL stop_no_other: data_valid %0d parity_err %0d, required 0 and 0", nv, np);
      end
   endtask

   // Second start bit begins in the first frame's result cycle (rel 81),
   // so the second result lands 81 edges later, 80 full cycles in between.
   task automatic test_back_to_back();
      int vl[$]; int sp[$]; int ix[$];
      idle_line(4);
      data_in = 1'b0;                                    // rel 0
      for (int rel = 1; rel <= 175; rel++) begin
         tick();
         if (data_valid) vl.push_back(rel);
         if (data_samp_en) begin sp.push_back(rel); ix.push_back(int'(bit_idx)); end
         if (rel >= 81) data_in = frame_line(rel - 81, 8'hC3, 1'b0, 1'b0, 1'b1);
         else           data_in = frame_line(rel, 8'h5A, 1'b0, 1'b0, 1'b1);
      end
      n_cmp++;
      if (vl.size() != 2 || q_at(vl, 0) != 81 || q_at(vl, 1) != 162) begin
         n_bad++;
         $display("FAIL b2b_valid: count %0d at %0d,%0d, required 2 at 81,162",
                  vl.size(), q_at(vl, 0), q_at(vl, 1));
      end
      n_cmp++;
      if (sp.size() != 16 || q_at(sp, 8) != 93 || q_at(ix, 8) != 0 || q_at(ix, 15) != 7) begin
         n_bad++;
         $display("FAIL b2b_second_samp: count %0d sample8 at %0d idx %0d last idx %0d, required 16 at 93 idx 0 last 7",
                  sp.size(), q_at(sp, 8), q_at(ix, 8), q_at(ix, 15));
      end
   endtask

   // Reset during data bit 3 aborts silently; next frame decodes normally.
   task automatic test_reset_mid_frame();
      int vl[$]; int sp[$]; int ix[$];
      int stray = 0;
      idle_line(4);
      data_in = 1'b0;                                    // rel 0
      for (int rel = 1; rel <= 36; rel++) begin
         tick();
         if (rel == 36) begin
            n_cmp++;
            if (data_samp_en !== 1'b1 || bit_idx !== 3'd3) begin
               n_bad++;
               $display("FAIL rstmid_pre: data_samp_en %b bit_idx %0d, required 1 and 3", data_samp_en, bit_idx);
            end
         end
         data_in = frame_line(rel, 8'h96, 1'b0, 1'b0, 1'b1);
      end
      rst = 1'b0;
      #1;
      n_cmp++;
      if (outs !== 11'd0) begin
         n_bad++;
         $display("FAIL rstmid_outputs: got %b, required all zero", outs);
      end
      data_in = 1'b1;
      repeat (3) tick();
      rst = 1'b1;
      for (int i = 0; i < 60; i++) begin
         tick();
         if (outs !== 11'd0) stray++;
      end
      n_cmp++;
      if (stray != 0) begin
         n_bad++;
         $display("FAIL rstmid_silent: %0d cycles with outputs active, required 0", stray);
      end
      data_in = 1'b0;                                    // rel 0
      for (int rel = 1; rel <= 100; rel++) begin
         tick();
         if (data_valid) vl.push_back(rel);
         if (data_samp_en) begin sp.push_back(rel); ix.push_back(int'(bit_idx)); end
         data_in = frame_line(rel, 8'h81, 1'b0, 1'b0, 1'b1);
      end
      n_cmp++;
      if (vl.size() != 1 || q_at(vl, 0) != 81 || sp.size() != 8 || q_at(sp, 7) != 68 || q_at(ix, 7) != 7) begin
         n_bad++;
         $display("FAIL rstmid_next_frame: valid %0d at %0d samp %0d last at %0d idx %0d, required 1 at 81, 8 last at 68 idx 7",
                  vl.size(), q_at(vl, 0), sp.size(), q_at(sp, 7), q_at(ix, 7));
      end
   endtask

   initial begin
      test_reset();
      test_clean_frame();
      test_glitch();
      test_parity();
      test_stop_err();
      test_back_to_back();
      test_reset_mid_frame();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL timeout: simulation exceeded 1 ms, required completion");
      $fatal(1, "timeout");
   end

endmodule : tb_uart_rx_fsm
`default_nettype wire
